// File: rtl/zjh_cmp_pkg.sv
// Shared encodings and constants for the sequential nibble-serial magnitude comparator.
package zjh_cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned NIB_W = 4;

   // Cascade seed (g,s,e): "equal so far" so the lowest nibble decides on its own.
   localparam logic [2:0] CASC_INIT = 3'b001;

endpackage

// File: rtl/zjh_74HC85.sv
// Behavioural model of one 74HC85 4-bit magnitude comparator with cascade inputs.
module zjh_74HC85
   import zjh_cmp_pkg::*;
(
   input  logic [NIB_W-1:0] A,
   input  logic [NIB_W-1:0] B,
   input  logic             IAGB,
   input  logic             IASB,
   input  logic             IAEB,
   output logic             QAGB,
   output logic             QASB,
   output logic             QAEB
);

   always_comb begin
      QAGB = 1'b0;
      QASB = 1'b0;
      QAEB = 1'b0;
      if (A > B) begin
         QAGB = 1'b1;
      end else if (A < B) begin
         QASB = 1'b1;
      end else if (IAEB) begin
         QAEB = 1'b1;
      end else begin
         // Equal nibbles with IAEB low follow the device's cross-coupled truth table.
         QAGB = ~IASB;
         QASB = ~IAGB;
      end
   end

endmodule

// File: rtl/zjh_cmp_seq.sv
// Time-multiplexes one 74HC85 across a WIDTH-bit operand pair, LSB nibble first,
// feeding each step's outputs back as the next step's cascade inputs.
module zjh_cmp_seq
   import zjh_cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic             AGB,
   output logic             ASB,
   output logic             AEB
);

   localparam int unsigned NIB   = WIDTH / NIB_W;
   localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_bad_width
      $error("zjh_cmp_seq: WIDTH must be a multiple of 4 and at least 4");
   end

   state_t             state;
   state_t             state_n;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               g;
   logic               s;
   logic               e;
   logic [CNT_W-1:0]   cnt;
   logic               last;
   logic               accept;
   logic               step;
   logic               qagb;
   logic               qasb;
   logic               qaeb;

   zjh_74HC85 u_cmp (
      .A    (a_q[NIB_W-1:0]),
      .B    (b_q[NIB_W-1:0]),
      .IAGB (g),
      .IASB (s),
      .IAEB (e),
      .QAGB (qagb),
      .QASB (qasb),
      .QAEB (qaeb)
   );

   assign last = (cnt == CNT_W'(NIB - 1));

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      accept  = 1'b0;
      step    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) begin
               accept  = 1'b1;
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            BUSY = 1'b1;
            step = 1'b1;
            if (last) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            BUSY    = 1'b1;
            DONE    = 1'b1;
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Operand shifters, cascade state, step counter and result registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         a_q       <= '0;
         b_q       <= '0;
         {g, s, e} <= CASC_INIT;
         cnt       <= '0;
         AGB       <= 1'b0;
         ASB       <= 1'b0;
         AEB       <= 1'b0;
      end else if (accept) begin
         a_q       <= A;
         b_q       <= B;
         {g, s, e} <= CASC_INIT;
         cnt       <= '0;
      end else if (step) begin
         a_q       <= a_q >> NIB_W;
         b_q       <= b_q >> NIB_W;
         {g, s, e} <= {qagb, qasb, qaeb};
         cnt       <= cnt + CNT_W'(1);
         if (last) begin
            AGB <= qagb;
            ASB <= qasb;
            AEB <= qaeb;
         end
      end
   end

endmodule

// File: tb/tb_zjh_cmp_seq.sv
// Directed and random bench for zjh_cmp_seq at WIDTH=16, plus a WIDTH=4 instance.
module tb_zjh_cmp_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic        agb;
   logic        asb;
   logic        aeb;

   logic        start4;
   logic [3:0]  a4;
   logic [3:0]  b4;
   logic        busy4;
   logic        done4;
   logic        agb4;
   logic        asb4;
   logic        aeb4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  exp;   // {AGB, ASB, AEB}
      string       nm;
   } vec_t;

   vec_t vecs[8];

   zjh_cmp_seq #(.WIDTH(16)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .START (start),
      .A     (a),
      .B     (b),
      .BUSY  (busy),
      .DONE  (done),
      .AGB   (agb),
      .ASB   (asb),
      .AEB   (aeb)
   );

   zjh_cmp_seq #(.WIDTH(4)) dut4 (
      .CLK   (clk),
      .RST_N (rst_n),
      .START (start4),
      .A     (a4),
      .B     (b4),
      .BUSY  (busy4),
      .DONE  (done4),
      .AGB   (agb4),
      .ASB   (asb4),
      .AEB   (aeb4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One full operation from IDLE: START sampled at the next edge, DONE five cycles later.
   task automatic run16(input logic [15:0] va, input logic [15:0] vb,
                        input logic [2:0] exp, input string nm);
      int n;
      a     = va;
      b     = vb;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      chk({nm, " busy"}, 32'(busy), 32'd1);
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk({nm, " latency"}, 32'(n), 32'd5);
      chk({nm, " result"}, 32'({agb, asb, aeb}), 32'(exp));
      tick();
      chk({nm, " done/busy clear"}, 32'({done, busy}), 32'd0);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [2:0]  rexp;
      int          k;
      logic        done_seen;

      vecs[0] = '{16'h1234, 16'h1234, 3'b001, "eq_1234"};
      vecs[1] = '{16'h1233, 16'h1234, 3'b010, "lsb_less"};
      vecs[2] = '{16'h8000, 16'h7FFF, 3'b100, "msb_greater"};
      vecs[3] = '{16'h0F00, 16'h0EFF, 3'b100, "high_overrides"};
      vecs[4] = '{16'h0000, 16'h0000, 3'b001, "eq_zero"};
      vecs[5] = '{16'hFFFF, 16'h0000, 3'b100, "max_vs_zero"};
      vecs[6] = '{16'h7FFF, 16'h8000, 3'b010, "msb_less"};
      vecs[7] = '{16'h0001, 16'h0000, 3'b100, "lsb_greater"};

      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      start4 = 1'b0;
      a4     = '0;
      b4     = '0;
      tick();
      tick();
      chk("reset outputs", 32'({busy, done, agb, asb, aeb}), 32'd0);
      chk("reset outputs w4", 32'({busy4, done4, agb4, asb4, aeb4}), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run16(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);
      end

      // Re-pulsed START mid-operation and in the DONE cycle; operands change after capture.
      for (int cyc = 0; cyc <= 12; cyc++) begin
         if (cyc > 0) begin
            chk($sformatf("repulse done c%0d", cyc), 32'(done),
                32'((cyc == 5) || (cyc == 11)));
            chk($sformatf("repulse busy c%0d", cyc), 32'(busy),
                32'(((cyc >= 1) && (cyc <= 5)) || ((cyc >= 7) && (cyc <= 11))));
            if (cyc == 5)  chk("repulse first result", 32'({agb, asb, aeb}), 32'b010);
            if (cyc == 11) chk("repulse second result", 32'({agb, asb, aeb}), 32'b100);
         end
         if (cyc == 0) begin
            a = 16'h0001;
            b = 16'h0002;
         end else begin
            a = 16'hFFFF;
            b = 16'h0000;
         end
         start = (cyc == 0) || (cyc == 2) || (cyc == 5) || (cyc == 6);
         tick();
      end
      start = 1'b0;

      // Reset during RUN aborts with no DONE and clears the previous AGB result.
      a     = 16'h1234;
      b     = 16'h1234;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("abort outputs", 32'({busy, done, agb, asb, aeb}), 32'd0);
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) done_seen = 1'b1;
      end
      chk("abort no done", 32'(done_seen), 32'd0);
      run16(16'h00F0, 16'h0F00, 3'b010, "after_abort");

      // WIDTH=4: single RUN cycle, DONE two cycles after START.
      a4     = 4'h3;
      b4     = 4'h5;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4     = 4'hF;
      chk("w4 busy run", 32'({busy4, done4}), 32'b10);
      tick();
      chk("w4 done", 32'({busy4, done4}), 32'b11);
      chk("w4 result", 32'({agb4, asb4, aeb4}), 32'b010);
      tick();
      chk("w4 idle", 32'({busy4, done4}), 32'b00);

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 2))
            0: rb = 16'($urandom);
            1: rb = ra;
            default: begin
               k  = $urandom_range(0, 3);
               rb = ra;
               rb[k*4 +: 4] = 4'($urandom);
            end
         endcase
         rexp = (ra > rb) ? 3'b100 : ((ra < rb) ? 3'b010 : 3'b001);
         run16(ra, rb, rexp, $sformatf("rand%0d %h/%h", i, ra, rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, limit 2000000 expected less");
      $fatal(1);
   end

endmodule
